// File: rtl/oram_axi_wr_pkg.sv
// Shared types for the ORAM-to-AXI burst writer:
// FSM states, AXI constants and the AWSIZE helper.
package oram_axi_wr_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_DRAIN
   } state_e;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   function automatic logic [2:0] axi_size(input int data_w);
      return 3'($clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/oram_axi_wr_if.sv
// AXI write channels (AW, W, B) between the writer
// and the memory-side slave.
interface oram_axi_wr_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 64,
   parameter int ID_W   = 4
);
   logic [ID_W-1:0]     AWID;
   logic [ADDR_W-1:0]   AWADDR;
   logic [7:0]          AWLEN;
   logic [2:0]          AWSIZE;
   logic [1:0]          AWBURST;
   logic                AWVALID;
   logic                AWREADY;
   logic [DATA_W-1:0]   WDATA;
   logic [DATA_W/8-1:0] WSTRB;
   logic                WLAST;
   logic                WVALID;
   logic                WREADY;
   logic [ID_W-1:0]     BID;
   logic [1:0]          BRESP;
   logic                BVALID;
   logic                BREADY;

   modport master (
      output AWID, AWADDR, AWLEN, AWSIZE,
      output AWBURST, AWVALID,
      input  AWREADY,
      output WDATA, WSTRB, WLAST, WVALID,
      input  WREADY,
      input  BID, BRESP, BVALID,
      output BREADY
   );

   modport slave (
      input  AWID, AWADDR, AWLEN, AWSIZE,
      input  AWBURST, AWVALID,
      output AWREADY,
      input  WDATA, WSTRB, WLAST, WVALID,
      output WREADY,
      output BID, BRESP, BVALID,
      input  BREADY
   );

endinterface

// File: rtl/oram_axi_wr_fifo.sv
// Two-entry data FIFO between the ORAM read port
// and the AXI W channel.
module wr_skid_fifo #(
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              pop_i,
   output logic [DATA_W-1:0] head_o,
   output logic [1:0]        cnt_o
);

   logic [1:0][DATA_W-1:0] mem_q, mem_d;
   logic                   wp_q, wp_d;
   logic                   rp_q, rp_d;
   logic [1:0]             cnt_q, cnt_d;

   always_comb begin
      mem_d = mem_q;
      wp_d  = wp_q;
      rp_d  = rp_q;
      if (push_i) begin
         mem_d[wp_q] = data_i;
         wp_d        = ~wp_q;
      end
      if (pop_i) rp_d = ~rp_q;
      cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q <= '0;
         wp_q  <= 1'b0;
         rp_q  <= 1'b0;
         cnt_q <= 2'd0;
      end else begin
         mem_q <= mem_d;
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         cnt_q <= cnt_d;
      end
   end

   assign head_o = mem_q[rp_q];
   assign cnt_o  = cnt_q;

endmodule

// File: rtl/oram_axi_wr.sv
// Streams contiguous ORAM words out as a series of
// strided AXI INCR write bursts.
module oram_axi_wr
   import oram_axi_wr_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 64,
   parameter int ID_W    = 4,
   parameter int MAX_OUT = 4,
   parameter int ORAM_AW = 12
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cmd_vld,
   output logic               cmd_rdy,
   input  logic [ADDR_W-1:0]  cmd_addr,
   input  logic [ADDR_W-1:0]  cmd_stride,
   input  logic [7:0]         cmd_len,
   input  logic [3:0]         cmd_num,
   input  logic [ORAM_AW-1:0] cmd_oram_addr,
   output logic               oram_rd_en,
   output logic [ORAM_AW-1:0] oram_rd_addr,
   input  logic [DATA_W-1:0]  oram_rd_data,
   oram_axi_wr_if.master      axi,
   output logic               busy,
   output logic               done,
   output logic               err
);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [ADDR_W-1:0]   stride_q, stride_d;
   logic [7:0]          len_q, len_d;
   logic [7:0]          beat_q, beat_d;
   logic [3:0]          num_q, num_d;
   logic [3:0]          bidx_q, bidx_d;
   logic [3:0]          outst_q, outst_d;
   logic [ORAM_AW-1:0]  raddr_q, raddr_d;
   logic [8:0]          rcnt_q, rcnt_d;
   logic                infl_q, infl_d;
   logic                err_q, err_d;

   logic                aw_vld, w_vld, rd_en;
   logic                aw_hs, w_hs, b_hs, last;
   logic [1:0]          f_cnt;
   logic [DATA_W-1:0]   f_head;

   wr_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push_i (infl_q),
      .data_i (oram_rd_data),
      .pop_i  (w_hs),
      .head_o (f_head),
      .cnt_o  (f_cnt)
   );

   // A read is allowed only while FIFO plus in-flight word
   // leaves room, and only for beats of the current burst.
   always_comb begin
      aw_vld = state_q == S_ADDR && outst_q < 4'(MAX_OUT);
      w_vld  = f_cnt != 2'd0;
      rd_en  = state_q == S_DATA
               && ({1'b0, f_cnt} + {2'b0, infl_q}) < 3'd2
               && rcnt_q <= {1'b0, len_q};
      aw_hs  = aw_vld && axi.AWREADY;
      w_hs   = w_vld && axi.WREADY;
      b_hs   = state_q != S_IDLE && axi.BVALID;
      last   = beat_q == len_q;
   end

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      stride_d = stride_q;
      len_d    = len_q;
      num_d    = num_q;
      bidx_d   = bidx_q;
      raddr_d  = raddr_q;
      rcnt_d   = rcnt_q;
      beat_d   = beat_q;
      err_d    = err_q;
      infl_d   = rd_en;
      outst_d  = outst_q + 4'(aw_hs) - 4'(b_hs);
      if (b_hs && axi.BRESP != RESP_OKAY) err_d = 1'b1;
      if (rd_en) begin
         raddr_d = raddr_q + 1'b1;
         rcnt_d  = rcnt_q + 9'd1;
      end
      if (w_hs) beat_d = beat_q + 8'd1;
      unique case (state_q)
         S_IDLE: if (cmd_vld) begin
            addr_d   = cmd_addr;
            stride_d = cmd_stride;
            len_d    = cmd_len;
            num_d    = cmd_num;
            raddr_d  = cmd_oram_addr;
            bidx_d   = 4'd0;
            err_d    = 1'b0;
            state_d  = S_ADDR;
         end
         S_ADDR: if (aw_hs) begin
            rcnt_d  = 9'd0;
            beat_d  = 8'd0;
            state_d = S_DATA;
         end
         S_DATA: if (w_hs && last) begin
            if (bidx_q == num_q) begin
               state_d = S_DRAIN;
            end else begin
               bidx_d  = bidx_q + 4'd1;
               addr_d  = addr_q + stride_q;
               state_d = S_ADDR;
            end
         end
         S_DRAIN: if (outst_q == 4'd0) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         addr_q   <= '0;
         stride_q <= '0;
         len_q    <= 8'd0;
         num_q    <= 4'd0;
         bidx_q   <= 4'd0;
         raddr_q  <= '0;
         rcnt_q   <= 9'd0;
         beat_q   <= 8'd0;
         outst_q  <= 4'd0;
         infl_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         stride_q <= stride_d;
         len_q    <= len_d;
         num_q    <= num_d;
         bidx_q   <= bidx_d;
         raddr_q  <= raddr_d;
         rcnt_q   <= rcnt_d;
         beat_q   <= beat_d;
         outst_q  <= outst_d;
         infl_q   <= infl_d;
         err_q    <= err_d;
      end
   end

   // Every output is forced low while reset is held.
   always_comb begin
      cmd_rdy      = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      err          = 1'b0;
      oram_rd_en   = 1'b0;
      oram_rd_addr = '0;
      axi.AWID     = '0;
      axi.AWADDR   = '0;
      axi.AWLEN    = 8'd0;
      axi.AWSIZE   = 3'd0;
      axi.AWBURST  = 2'd0;
      axi.AWVALID  = 1'b0;
      axi.WDATA    = '0;
      axi.WSTRB    = '0;
      axi.WLAST    = 1'b0;
      axi.WVALID   = 1'b0;
      axi.BREADY   = 1'b0;
      if (!rst) begin
         cmd_rdy      = state_q == S_IDLE;
         busy         = state_q != S_IDLE;
         done         = state_q == S_DRAIN
                        && outst_q == 4'd0;
         err          = err_q;
         oram_rd_en   = rd_en;
         oram_rd_addr = raddr_q;
         axi.AWID     = ID_W'(bidx_q);
         axi.AWADDR   = addr_q;
         axi.AWLEN    = len_q;
         axi.AWSIZE   = axi_size(DATA_W);
         axi.AWBURST  = BURST_INCR;
         axi.AWVALID  = aw_vld;
         axi.WDATA    = f_head;
         axi.WSTRB    = '1;
         axi.WLAST    = last;
         axi.WVALID   = w_vld;
         axi.BREADY   = state_q != S_IDLE;
      end
   end

endmodule
